// File: rtl/aqms_pkg.sv
// Shared constants for the AQMS memory mapper: slot geometry, register window
// offsets, ramctrl bit positions and small address-decode helpers.
package aqms_pkg;

  localparam int SLOT_SIZE  = 16384;
  localparam int SLOT_SHIFT = $clog2(SLOT_SIZE);

  // Offsets inside the register window that starts at REG_BASE.
  localparam logic [1:0] REG_OFF_RAMCTRL = 2'd0;
  localparam logic [1:0] REG_OFF_BANK0   = 2'd1;

  localparam int CARTRAM_EN_BIT   = 3;
  localparam int CARTRAM_PAGE_BIT = 2;

  function automatic logic [1:0] slot_of(input logic [15:0] addr);
    return 2'(addr >> SLOT_SHIFT);
  endfunction

  // Window test is done in 17 bits so REG_BASE+n never wraps past 0xFFFF.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int          n);
    return ({1'b0, addr} >= {1'b0, base}) &&
           ({1'b0, addr} <= ({1'b0, base} + 17'(n)));
  endfunction

  function automatic logic [1:0] win_off(input logic [1:0] addr_lo,
                                         input logic [1:0] base_lo);
    return addr_lo - base_lo;
  endfunction

endpackage

// File: rtl/bus_strobe_sync.sv
// Three-flop synchroniser for an active-low CPU strobe with a falling-edge
// detector that stays disarmed after reset until the strobe is seen high.
module bus_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n,
  output logic idle,
  output logic fall
);

  logic [2:0] stage;
  logic [1:0] valid;
  logic       armed;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= 3'b111;
      valid <= 2'b00;
      armed <= 1'b0;
    end else begin
      stage <= {stage[1:0], strobe_n};
      valid <= {valid[0], 1'b1};
      // Only a genuinely sampled high arms the detector, so a strobe still
      // low when reset is released cannot be mistaken for a new edge.
      armed <= armed | (valid[1] & stage[1]);
    end
  end

  assign idle = stage[0];
  assign fall = armed & stage[2] & ~stage[1];

endmodule

// File: rtl/aqms_mapper.sv
// AQMS banked memory mapper: bank/ramctrl registers, bank address and RAM
// strobes. Optional cartridge RAM paging in slot 2: AQMS_MAPPER_CARTRAM_EN.
module aqms_mapper
  import aqms_pkg::*;
#(
  parameter int          NUM_SLOTS = 3,
  parameter int          BANK_W    = 5,
  parameter logic [15:0] FIXED_LEN = 16'h0400,
  parameter logic [15:0] REG_BASE  = 16'hFFFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       bus_a,
  input  logic [7:0]        bus_d_in,
  input  logic              bus_rd_n,
  input  logic              bus_wr_n,
  input  logic              bus_mreq_n,
  input  logic              sel_internal,
  output logic [BANK_W-1:0] ba,
  output logic              ram_ce_n,
  output logic              ram_we_n,
  output logic              startup_mode,
  output logic [7:0]        ramctrl,
  output logic              reg_hit,
  output logic [7:0]        reg_rddata,
  output logic              bank_changed,
  output logic              cartram_ce_n
);

  logic wr_idle, wr_fall, rd_idle, rd_fall;

  bus_strobe_sync u_wr_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (bus_wr_n),
    .idle     (wr_idle),
    .fall     (wr_fall)
  );

  bus_strobe_sync u_rd_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (bus_rd_n),
    .idle     (rd_idle),
    .fall     (rd_fall)
  );

  // A Z80 never overlaps read and write strobes; treat overlap as a glitch.
  logic wr_evt;
  assign wr_evt = wr_fall & rd_idle & ~rd_fall;

  logic [15:0]       cap_a;
  logic [7:0]        cap_d;
  logic              cap_mreq_n;
  logic              wr_pending;
  logic [7:0]        ramctrl_q;
  logic              startup_q;
  logic              bank_changed_q;
  logic [BANK_W-1:0] bank_q [NUM_SLOTS];

  // Bus is tracked until the strobe is first registered low, then frozen until
  // the write lands, so an early strobe release cannot corrupt it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_a      <= '0;
      cap_d      <= '0;
      cap_mreq_n <= 1'b1;
      wr_pending <= 1'b0;
    end else begin
      wr_pending <= wr_evt;
      if (wr_idle && !wr_fall && !wr_pending) begin
        cap_a      <= bus_a;
        cap_d      <= bus_d_in;
        cap_mreq_n <= bus_mreq_n;
      end
    end
  end

  logic       wr_hit;
  logic [1:0] wr_off;
  assign wr_hit = wr_pending & ~cap_mreq_n & in_window(cap_a, REG_BASE, NUM_SLOTS);
  assign wr_off = win_off(cap_a[1:0], REG_BASE[1:0]);

  // NOTE: the bank register array is small and holds architectural reset
  // values, so every entry is reset explicitly rather than left as RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramctrl_q      <= 8'h00;
      startup_q      <= 1'b1;
      bank_changed_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) bank_q[i] <= BANK_W'(i);
    end else begin
      bank_changed_q <= 1'b0;
      if (wr_hit) begin
        if (wr_off == REG_OFF_RAMCTRL) begin
          ramctrl_q <= cap_d;
          startup_q <= 1'b0;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (wr_off == REG_OFF_BANK0 + 2'(i)) begin
            bank_q[i]      <= cap_d[BANK_W-1:0];
            bank_changed_q <= 1'b1;
          end
        end
      end
    end
  end

  logic cart_sel;
  logic mem_sel;
  logic ram_ce;

`ifdef AQMS_MAPPER_CARTRAM_EN
  assign cart_sel = (NUM_SLOTS == 3) && ramctrl_q[CARTRAM_EN_BIT] &&
                    (slot_of(bus_a) == 2'd2);
  assign cartram_ce_n = ~(mem_sel & cart_sel);
`else
  assign cart_sel     = 1'b0;
  assign cartram_ce_n = 1'b1;
`endif

  // NOTE: every combinational output gets a default first, so no path
  // through the decode can leave it unassigned and infer a latch.
  always_comb begin
    ba = '0;
    if (bus_a >= FIXED_LEN) begin
      if (cart_sel) begin
        ba = BANK_W'(ramctrl_q[CARTRAM_PAGE_BIT]);
      end else begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (slot_of(bus_a) == 2'(i)) ba = bank_q[i];
        end
      end
    end
  end

  assign mem_sel  = ~bus_mreq_n & ~sel_internal;
  assign ram_ce   = mem_sel & ~cart_sel & (bus_wr_n | startup_q);
  assign ram_ce_n = ~ram_ce;
  assign ram_we_n = ~(ram_ce & ~bus_wr_n & startup_q);

  assign reg_hit = ~bus_mreq_n & in_window(bus_a, REG_BASE, NUM_SLOTS);

  always_comb begin
    reg_rddata = 8'hFF;
    if (reg_hit) begin
      if (win_off(bus_a[1:0], REG_BASE[1:0]) == REG_OFF_RAMCTRL) reg_rddata = ramctrl_q;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (win_off(bus_a[1:0], REG_BASE[1:0]) == REG_OFF_BANK0 + 2'(i))
          reg_rddata = 8'(bank_q[i]);
      end
    end
  end

  assign startup_mode = startup_q;
  assign ramctrl      = ramctrl_q;
  assign bank_changed = bank_changed_q;

endmodule

// File: tb/tb_aqms_mapper.sv
// Directed bench for aqms_mapper: combinational decode table plus write,
// early-release, reset-abort and cartridge-RAM sequences.
module tb_aqms_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_a;
  logic [7:0]  bus_d_in;
  logic        bus_rd_n, bus_wr_n, bus_mreq_n, sel_internal;
  logic [4:0]  ba;
  logic        ram_ce_n, ram_we_n, startup_mode, reg_hit, bank_changed, cartram_ce_n;
  logic [7:0]  ramctrl, reg_rddata;

  aqms_mapper dut (
    .clk          (clk),
    .reset        (reset),
    .bus_a        (bus_a),
    .bus_d_in     (bus_d_in),
    .bus_rd_n     (bus_rd_n),
    .bus_wr_n     (bus_wr_n),
    .bus_mreq_n   (bus_mreq_n),
    .sel_internal (sel_internal),
    .ba           (ba),
    .ram_ce_n     (ram_ce_n),
    .ram_we_n     (ram_we_n),
    .startup_mode (startup_mode),
    .ramctrl      (ramctrl),
    .reg_hit      (reg_hit),
    .reg_rddata   (reg_rddata),
    .bank_changed (bank_changed),
    .cartram_ce_n (cartram_ce_n)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  always @(negedge clk) if (bank_changed === 1'b1) pulse_cnt++;

  typedef struct {
    logic [15:0] a;
    logic        mreq_n, wr_n, sel;
    logic [4:0]  ba;
    logic        ce_n, we_n, hit;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d,
                       input logic mreq_n, input logic wr_n, input logic sel);
    bus_a        = a;
    bus_d_in     = d;
    bus_mreq_n   = mreq_n;
    bus_wr_n     = wr_n;
    bus_rd_n     = 1'b1;
    sel_internal = sel;
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
    drive(a, d, 1'b0, 1'b0, 1'b0);
    step(5);
    drive(a, d, 1'b1, 1'b1, 1'b0);
    step(5);
  endtask

  int pc;

  initial begin
    //            a         mreq wr  sel  ba     ce  we  hit  rd
    tbl[0]  = '{16'h4000, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 8'hFF};
    tbl[1]  = '{16'h8000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 8'hFF};
    tbl[2]  = '{16'hC000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'hFF};
    tbl[3]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'hFF};
    tbl[4]  = '{16'h8000, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[5]  = '{16'h8000, 1'b0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[6]  = '{16'hFFFC, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[7]  = '{16'hFFFD, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[8]  = '{16'hFFFE, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 8'h01};
    tbl[9]  = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 8'h02};
    tbl[10] = '{16'hFFFB, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'hFF};
    tbl[11] = '{16'hFFFE, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[12] = '{16'h7FFF, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 8'hFF};
    tbl[13] = '{16'h4000, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hFF};

    reset = 1'b1;
    drive(16'h0000, 8'h00, 1'b1, 1'b1, 1'b0);
    step(3);
    reset = 1'b0;
    step(4);

    check("rst startup_mode", 16'(startup_mode), 16'h1);
    check("rst ramctrl", 16'(ramctrl), 16'h00);
    check("rst bank_changed", 16'(bank_changed), 16'h0);
    check("rst cartram_ce_n", 16'(cartram_ce_n), 16'h1);
    check("rst ram_ce_n idle", 16'(ram_ce_n), 16'h1);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].a, 8'h00, tbl[i].mreq_n, tbl[i].wr_n, tbl[i].sel);
      #2;
      check($sformatf("v%0d ba", i), 16'(ba), 16'(tbl[i].ba));
      check($sformatf("v%0d ram_ce_n", i), 16'(ram_ce_n), 16'(tbl[i].ce_n));
      check($sformatf("v%0d ram_we_n", i), 16'(ram_we_n), 16'(tbl[i].we_n));
      check($sformatf("v%0d reg_hit", i), 16'(reg_hit), 16'(tbl[i].hit));
      check($sformatf("v%0d reg_rddata", i), 16'(reg_rddata), 16'(tbl[i].rd));
      step(1);
    end
    drive(16'h0000, 8'h00, 1'b1, 1'b1, 1'b0);
    step(6);

    // Bank 2 <= 0x13: bus_wr_n first sampled low at E1, update lands on E4.
    pc = pulse_cnt;
    drive(16'hFFFF, 8'h13, 1'b0, 1'b0, 1'b0);
    step(3);
    check("wr13 bank2 before E4", 16'(reg_rddata), 16'h02);
    check("wr13 no pulse before E4", 16'(bank_changed), 16'h0);
    step(1);
    check("wr13 bank2 at E4", 16'(reg_rddata), 16'h13);
    check("wr13 pulse at E4", 16'(bank_changed), 16'h1);
    step(1);
    check("wr13 pulse ends", 16'(bank_changed), 16'h0);
    step(2);
    drive(16'h8000, 8'h00, 1'b0, 1'b1, 1'b0);
    step(4);
    check("wr13 ba at 8000", 16'(ba), 16'h13);
    check("wr13 pulse count", 16'(pulse_cnt - pc), 16'd1);

    // Bank 0 <= 0x07 with the strobe released after one sample and the bus moved.
    pc = pulse_cnt;
    drive(16'hFFFD, 8'h07, 1'b0, 1'b0, 1'b0);
    step(1);
    drive(16'hFFFE, 8'h1E, 1'b0, 1'b1, 1'b0);
    step(6);
    check("short wr bank1 kept", 16'(reg_rddata), 16'h01);
    drive(16'hFFFD, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
    check("short wr bank0", 16'(reg_rddata), 16'h07);
    check("short wr pulse count", 16'(pulse_cnt - pc), 16'd1);
    drive(16'h0200, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
    check("fixed 0200 ba", 16'(ba), 16'h00);
    drive(16'h03FF, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
    check("fixed 03FF ba", 16'(ba), 16'h00);
    drive(16'h0400, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
    check("slot0 0400 ba", 16'(ba), 16'h07);
    step(2);

    // ramctrl <= 0x00 closes the startup window: RAM writes are blocked.
    reg_write(16'hFFFC, 8'h00);
    check("ramctrl wr startup_mode", 16'(startup_mode), 16'h0);
    check("ramctrl wr value", 16'(ramctrl), 16'h00);
    drive(16'h4000, 8'h55, 1'b0, 1'b0, 1'b0);
    #2;
    check("post-boot wr ram_ce_n", 16'(ram_ce_n), 16'h1);
    check("post-boot wr ram_we_n", 16'(ram_we_n), 16'h1);
    drive(16'h4000, 8'h55, 1'b0, 1'b1, 1'b0);
    #2;
    check("post-boot rd ram_ce_n", 16'(ram_ce_n), 16'h0);
    step(6);

    // Reset pulsed one clock into a write of 0x1F to bank 1 must abort it.
    pc = pulse_cnt;
    drive(16'hFFFE, 8'h1F, 1'b0, 1'b0, 1'b0);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(4);
    drive(16'hFFFE, 8'h1F, 1'b0, 1'b1, 1'b0);
    step(6);
    check("abort bank1", 16'(reg_rddata), 16'h01);
    check("abort pulse count", 16'(pulse_cnt - pc), 16'd0);
    check("abort startup_mode", 16'(startup_mode), 16'h1);
    step(4);

    // ramctrl <= 0x0C, then a memory write into slot 2.
    reg_write(16'hFFFC, 8'h0C);
    check("cart ramctrl", 16'(ramctrl), 16'h0C);
    drive(16'h8000, 8'hAA, 1'b0, 1'b0, 1'b0);
    #2;
`ifdef AQMS_MAPPER_CARTRAM_EN
    check("cart wr cartram_ce_n", 16'(cartram_ce_n), 16'h0);
    check("cart wr ram_ce_n", 16'(ram_ce_n), 16'h1);
    check("cart wr ba", 16'(ba), 16'h01);
`else
    check("cart wr cartram_ce_n", 16'(cartram_ce_n), 16'h1);
    check("cart wr ram_ce_n", 16'(ram_ce_n), 16'h1);
    check("cart wr ba", 16'(ba), 16'h02);
`endif
    check("cart wr ram_we_n", 16'(ram_we_n), 16'h1);
    drive(16'h8000, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
`ifdef AQMS_MAPPER_CARTRAM_EN
    check("cart rd cartram_ce_n", 16'(cartram_ce_n), 16'h0);
    check("cart rd ram_ce_n", 16'(ram_ce_n), 16'h1);
    check("cart rd ba", 16'(ba), 16'h01);
`else
    check("cart rd cartram_ce_n", 16'(cartram_ce_n), 16'h1);
    check("cart rd ram_ce_n", 16'(ram_ce_n), 16'h0);
    check("cart rd ba", 16'(ba), 16'h02);
`endif
    drive(16'h4000, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
    check("slot1 ba with ramctrl 0C", 16'(ba), 16'h01);
    check("slot1 cartram_ce_n", 16'(cartram_ce_n), 16'h1);
    check("slot1 ram_ce_n", 16'(ram_ce_n), 16'h0);
    step(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
